alu_arbiter: RTL and testbench

Shares the single combinational ALU (A, B, ALUFun[5:0], Sign -> Z) between two requesters: port 0 is the pipeline EX stage and port 1 is an auxiliary unit such as the interrupt/peripheral address calculator. The block arbitrates round-robin, registers the operands, drives the ALU for one cycle, and captures Z. It returns Z to the requester with a valid/ready handshake and a requester ID. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/rr_arb2.sv | 31 +++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes, widths, arbiter state encoding and operand bundle.
package alu_pkg;

  localparam int unsigned ALU_W     = 32;
  localparam int unsigned ALU_FUN_W = 6;

  localparam logic [ALU_FUN_W-1:0] FUN_ADD   = 6'b000000;
  localparam logic [ALU_FUN_W-1:0] FUN_SUB   = 6'b000001;
  localparam logic [ALU_FUN_W-1:0] FUN_AND   = 6'b011000;
  localparam logic [ALU_FUN_W-1:0] FUN_OR    = 6'b011110;
  localparam logic [ALU_FUN_W-1:0] FUN_XOR   = 6'b010110;
  localparam logic [ALU_FUN_W-1:0] FUN_NOR   = 6'b010001;
  localparam logic [ALU_FUN_W-1:0] FUN_PASSA = 6'b011010;
  localparam logic [ALU_FUN_W-1:0] FUN_SLL   = 6'b100000;
  localparam logic [ALU_FUN_W-1:0] FUN_SRL   = 6'b100001;
  localparam logic [ALU_FUN_W-1:0] FUN_SRA   = 6'b100011;
  localparam logic [ALU_FUN_W-1:0] FUN_EQ    = 6'b110011;
  localparam logic [ALU_FUN_W-1:0] FUN_NEQ   = 6'b110001;
  localparam logic [ALU_FUN_W-1:0] FUN_LT    = 6'b110101;
  localparam logic [ALU_FUN_W-1:0] FUN_LEZ   = 6'b111101;
  localparam logic [ALU_FUN_W-1:0] FUN_LTZ   = 6'b111011;
  localparam logic [ALU_FUN_W-1:0] FUN_GTZ   = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ALU_W-1:0]     a;
    logic [ALU_W-1:0]     b;
    logic [ALU_FUN_W-1:0] fun;
    logic                 sign;
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the ALU arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic                 req0_valid;
  logic                 req0_ready;
  logic [ALU_W-1:0]     req0_a;
  logic [ALU_W-1:0]     req0_b;
  logic [ALU_FUN_W-1:0] req0_fun;
  logic                 req0_sign;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [ALU_W-1:0]     req1_a;
  logic [ALU_W-1:0]     req1_b;
  logic [ALU_FUN_W-1:0] req1_fun;
  logic                 req1_sign;

  logic [ALU_W-1:0]     alu_a;
  logic [ALU_W-1:0]     alu_b;
  logic [ALU_FUN_W-1:0] alu_fun;
  logic                 alu_sign;
  logic [ALU_W-1:0]     alu_z;

  logic                 rsp_valid;
  logic                 rsp_id;
  logic [ALU_W-1:0]     rsp_z;
  logic                 rsp_ready;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fun, req0_sign,
    input  req1_valid, req1_a, req1_b, req1_fun, req1_sign,
    input  alu_z, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_fun, alu_sign,
    output rsp_valid, rsp_id, rsp_z
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_fun, req0_sign,
    output req1_valid, req1_a, req1_b, req1_fun, req1_sign,
    output alu_z, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_fun, alu_sign,
    input  rsp_valid, rsp_id, rsp_z
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; remembers the last winner so a tie goes to the other port.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic grant0_o,
  output logic grant1_o,
  output logic gnt_id_o
);

  logic last_q, last_d;
  logic pick1;

  always_comb begin
    pick1    = valid1_i && (!valid0_i || !last_q);
    grant0_o = en_i && valid0_i && !pick1;
    grant1_o = en_i && pick1;
    gnt_id_o = pick1;
    last_d   = last_q;
    if (grant0_o || grant1_o) last_d = pick1;
  end

  // Starts at 1 so port 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional grant counters gnt0_cnt/gnt1_cnt are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]  gnt0_cnt,
  output logic [31:0]  gnt1_cnt
`endif
);

  state_e           state_q, state_d;
  alu_op_t          op_q, op_d;
  alu_op_t          req_op0, req_op1;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [ALU_W-1:0] rsp_z_q, rsp_z_d;
  logic             arb_en, grant0, grant1, gnt_id;

  assign req_op0 = {bus.req0_a, bus.req0_b, bus.req0_fun, bus.req0_sign};
  assign req_op1 = {bus.req1_a, bus.req1_b, bus.req1_fun, bus.req1_sign};

  // Requests are only taken in IDLE and never while reset is held.
  assign arb_en = (state_q == ST_IDLE) && !reset;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .en_i     (arb_en),
    .valid0_i (bus.req0_valid),
    .valid1_i (bus.req1_valid),
    .grant0_o (grant0),
    .grant1_o (grant1),
    .gnt_id_o (gnt_id)
  );

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          op_d     = gnt_id ? req_op1 : req_op0;
          rsp_id_d = gnt_id;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_z_d     = bus.alu_z;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_z_q     <= '0;
    end else begin
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
    end
  end

  assign bus.alu_a     = op_q.a;
  assign bus.alu_b     = op_q.b;
  assign bus.alu_fun   = op_q.fun;
  assign bus.alu_sign  = op_q.sign;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z     = rsp_z_q;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] gnt0_cnt_q, gnt1_cnt_q;

  // Free-running grant counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0_cnt_q <= 32'd0;
      gnt1_cnt_q <= 32'd0;
    end else begin
      if (grant0) gnt0_cnt_q <= gnt0_cnt_q + 32'd1;
      if (grant1) gnt1_cnt_q <= gnt1_cnt_q + 32'd1;
    end
  end

  assign gnt0_cnt = gnt0_cnt_q;
  assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic vs. a scoreboard.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  alu_arbiter_if bus ();
`ifdef ALU_ARB_STATS_EN
  logic [31:0] gnt0_cnt, gnt1_cnt;
`endif

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt0_cnt (gnt0_cnt),
    .gnt1_cnt (gnt1_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference ALU: shifts move B by A[4:0]; compares return 0/1 in bit 0.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] f, input logic s);
    case (f)
      FUN_ADD:   return a + b;
      FUN_SUB:   return a - b;
      FUN_AND:   return a & b;
      FUN_OR:    return a | b;
      FUN_XOR:   return a ^ b;
      FUN_NOR:   return ~(a | b);
      FUN_PASSA: return a;
      FUN_SLL:   return b << a[4:0];
      FUN_SRL:   return b >> a[4:0];
      FUN_SRA:   return 32'($signed(b) >>> a[4:0]);
      FUN_EQ:    return {31'd0, a == b};
      FUN_NEQ:   return {31'd0, a != b};
      FUN_LT:    return {31'd0, s ? ($signed(a) < $signed(b)) : (a < b)};
      FUN_LEZ:   return {31'd0, $signed(a) <= 0};
      FUN_LTZ:   return {31'd0, a[31]};
      FUN_GTZ:   return {31'd0, !a[31] && (a != 32'd0)};
      default:   return 32'd0;
    endcase
  endfunction

  always_comb bus.alu_z = alu_f(bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_sign);

  // Scoreboard state: at most one operation owns the ALU from grant to consumption.
  int          cyc = 0;
  bit          busy = 1'b0;
  int          acc_cyc = 0;
  bit          tb_last = 1'b1;
  logic        exp_id;
  logic [31:0] exp_z;

  // Values observed at the most recent falling edge.
  logic        s_r0, s_r1, s_rv, s_id, s_as;
  logic [31:0] s_z, s_aa, s_ab;
  logic [5:0]  s_af;
  int          s_gnt;

  logic [5:0]  codes [16];
  logic [31:0] sweep_exp [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f, input bit s);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_fun = f; bus.req0_sign = s;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_fun = f; bus.req1_sign = s;
    end
  endtask

  // One clock: observe at the falling edge, update the scoreboard, return just after the rising edge.
  task automatic step();
    int eg;
    @(negedge clk);
    cyc++;
    s_r0 = bus.req0_ready; s_r1 = bus.req1_ready;
    s_rv = bus.rsp_valid;  s_id = bus.rsp_id; s_z = bus.rsp_z;
    s_aa = bus.alu_a; s_ab = bus.alu_b; s_af = bus.alu_fun; s_as = bus.alu_sign;
    s_gnt = s_r0 ? 0 : (s_r1 ? 1 : -1);
    if (reset) begin
      chk("ready_in_reset", 32'({s_r0, s_r1}), 32'd0);
      busy    = 1'b0;
      tb_last = 1'b1;
    end else begin
      eg = -1;
      if (!busy) begin
        if (bus.req0_valid && bus.req1_valid) eg = tb_last ? 0 : 1;
        else if (bus.req0_valid)              eg = 0;
        else if (bus.req1_valid)              eg = 1;
      end
      chk("ready0", 32'(s_r0), 32'(eg == 0));
      chk("ready1", 32'(s_r1), 32'(eg == 1));
      if (busy && cyc >= acc_cyc + 2) begin
        chk("rsp_valid", 32'(s_rv), 32'd1);
        chk("rsp_id", 32'(s_id), 32'(exp_id));
        chk("rsp_z", s_z, exp_z);
        if (bus.rsp_ready) busy = 1'b0;
      end else begin
        chk("rsp_valid_low", 32'(s_rv), 32'd0);
      end
      if (eg >= 0) begin
        tb_last = eg[0];
        busy    = 1'b1;
        acc_cyc = cyc;
        exp_id  = eg[0];
        exp_z   = (eg == 0) ? alu_f(bus.req0_a, bus.req0_b, bus.req0_fun, bus.req0_sign)
                            : alu_f(bus.req1_a, bus.req1_b, bus.req1_fun, bus.req1_sign);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Issue one op on port p alone and let it complete with rsp_ready high.
  task automatic single_op(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] f, input bit s);
    set_req(p, 1'b1, a, b, f, s);
    step();
    chk("single_grant", 32'(s_gnt), 32'(p));
    set_req(p, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    step();
    step();
  endtask

  initial begin
    int          g [$];
    bit          rv [2];
    logic [31:0] ra [2], rb [2];
    logic [5:0]  rf [2];
    bit          rs [2];
    bit          took;

    codes = '{FUN_ADD, FUN_SUB, FUN_AND, FUN_OR, FUN_XOR, FUN_NOR, FUN_PASSA, FUN_SLL,
              FUN_SRL, FUN_SRA, FUN_EQ, FUN_NEQ, FUN_LT, FUN_LEZ, FUN_LTZ, FUN_GTZ};
    sweep_exp = '{32'd5, 32'd5, 32'd0, 32'd5, 32'd5, 32'hFFFF_FFFA, 32'd5, 32'd0,
                  32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};

    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    step();
    step();
    reset = 1'b0;

    // 1: first request after reset, with reset values visible in the same cycle
    set_req(0, 1'b1, 32'd5, 32'd0, FUN_ADD, 1'b1);
    step();
    chk("t1_ready0", 32'(s_r0), 32'd1);
    chk("t1_rst_alu_a", s_aa, 32'd0);
    chk("t1_rst_alu_b", s_ab, 32'd0);
    chk("t1_rst_alu_fun", 32'(s_af), 32'd0);
    chk("t1_rst_alu_sign", 32'(s_as), 32'd0);
    chk("t1_rst_rsp", {s_z[29:0], s_id, s_rv}, 32'd0);
    set_req(0, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    step();
    chk("t1_exec_alu_a", s_aa, 32'd5);
    chk("t1_exec_rv", 32'(s_rv), 32'd0);
    step();
    chk("t1_rv", 32'(s_rv), 32'd1);
    chk("t1_id", 32'(s_id), 32'd0);
    chk("t1_z", s_z, 32'd5);

    // 2: simultaneous requests, then continuous contention alternates
    do_reset();
    set_req(0, 1'b1, 32'd7, 32'd3, FUN_SUB, 1'b0);
    set_req(1, 1'b1, 32'hF0, 32'h0F, FUN_OR, 1'b0);
    step();
    chk("t2_first_gnt", 32'(s_gnt), 32'd0);
    set_req(0, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    step();
    step();
    chk("t2_z0", s_z, 32'd4);
    chk("t2_id0", 32'(s_id), 32'd0);
    step();
    chk("t2_second_gnt", 32'(s_gnt), 32'd1);
    set_req(1, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    step();
    step();
    chk("t2_z1", s_z, 32'hFF);
    chk("t2_id1", 32'(s_id), 32'd1);
    set_req(0, 1'b1, 32'd7, 32'd3, FUN_SUB, 1'b0);
    set_req(1, 1'b1, 32'hF0, 32'h0F, FUN_OR, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_gnt >= 0) g.push_back(s_gnt);
    end
    chk("t2_alt_count", 32'(g.size()), 32'd4);
    for (int i = 0; i < 4 && i < g.size(); i++) chk("t2_alt_seq", 32'(g[i]), 32'(i % 2));
    set_req(0, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);

    // 3: backpressure on a signed compare result
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, FUN_LT, 1'b1);
    step();
    chk("t3_gnt", 32'(s_gnt), 32'd0);
    set_req(0, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    set_req(1, 1'b1, 32'd3, 32'd4, FUN_ADD, 1'b0);
    step();
    step();
    chk("t3_z_first", s_z, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_z", s_z, 32'd1);
      chk("t3_hold_rv", 32'(s_rv), 32'd1);
      chk("t3_hold_ready", 32'({s_r0, s_r1}), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("t3_consume_rv", 32'(s_rv), 32'd1);
    step();
    chk("t3_idle_ready1", 32'(s_r1), 32'd1);
    set_req(1, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    step();
    step();

    // 4: every function code through port 1 with a=5, b=0
    for (int i = 0; i < 16; i++) begin
      set_req(1, 1'b1, 32'd5, 32'd0, codes[i], 1'b1);
      step();
      chk("t4_gnt", 32'(s_gnt), 32'd1);
      set_req(1, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
      step();
      step();
      chk($sformatf("t4_z_fun%06b", codes[i]), s_z, sweep_exp[i]);
    end

    // 5: reset while the ALU is executing
    set_req(0, 1'b1, 32'd9, 32'd9, FUN_ADD, 1'b0);
    step();
    chk("t5_gnt", 32'(s_gnt), 32'd0);
    set_req(0, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(1, 1'b1, 32'd2, 32'd3, FUN_ADD, 1'b0);
    step();
    chk("t5_rv_after_rst", 32'(s_rv), 32'd0);
    chk("t5_z_after_rst", s_z, 32'd0);
    chk("t5_ready1", 32'(s_r1), 32'd1);
    set_req(1, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    step();
    step();
    chk("t5_z1", s_z, 32'd5);
    set_req(0, 1'b1, 32'd1, 32'd1, FUN_ADD, 1'b0);
    set_req(1, 1'b1, 32'd2, 32'd2, FUN_ADD, 1'b0);
    step();
    chk("t5_tie_gnt", 32'(s_gnt), 32'd0);
    set_req(0, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, FUN_ADD, 1'b0);
    step();
    step();

`ifdef ALU_ARB_STATS_EN
    // 6: grant counters and wrap
    do_reset();
    for (int i = 0; i < 3; i++) single_op(0, 32'(i), 32'd1, FUN_ADD, 1'b0);
    for (int i = 0; i < 2; i++) single_op(1, 32'(i), 32'd2, FUN_ADD, 1'b0);
    chk("t6_cnt0", gnt0_cnt, 32'd3);
    chk("t6_cnt1", gnt1_cnt, 32'd2);
    force dut.gnt0_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.gnt0_cnt_q;
    single_op(0, 32'd1, 32'd1, FUN_ADD, 1'b0);
    chk("t6_wrap", gnt0_cnt, 32'd0);
`else
    single_op(0, 32'd4, 32'd4, FUN_XOR, 1'b0);
`endif

    // Random traffic obeying the hold-while-waiting rule
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0; ra[p] = '0; rb[p] = '0; rf[p] = FUN_ADD; rs[p] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        took = (p == 0) ? s_r0 : s_r1;
        if (!rv[p] || took) begin
          rv[p] = ($urandom % 3) != 0;
          ra[p] = $urandom;
          rb[p] = (($urandom % 4) == 0) ? ($urandom % 32) : $urandom;
          rf[p] = codes[$urandom % 16];
          rs[p] = $urandom % 2;
        end
        set_req(p, rv[p], ra[p], rb[p], rf[p], rs[p]);
      end
      bus.rsp_ready = ($urandom % 3) != 0;
      reset = (($urandom % 97) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
